bcd_scan_counter: RTL and testbench
===================================

// Module: bcd_scan_counter
// PURPOSE
//   Multi-digit BCD up/down counter with a time-base prescaler and a digit scanner.
//   Produces the 4-bit digit value consumed by the 7-segment decoder stage.
//   The decoder registers its output, so this block also supplies a one-hot
//   digit-enable delayed by one cycle. That enable is cycle-aligned with the
//   decoded segments and drives the digit commons.
// PARAMETERS
//   NUM_DIGITS  4        number of BCD decades; digit 0 is least significant
//   TICK_DIV    1000000  clk cycles per count tick (>=2)
//   SCAN_DIV    1000     clk cycles per scanned digit (>=2)
// PORTS
//   clk        in   1            system clock
//   rst_n      in   1            synchronous reset, active low
//   ena        in   1            global enable; low freezes all state
//   run        in   1            1 = count ticks advance the counter
//   up_dn      in   1            1 = count up, 0 = count down
//   clear      in   1            sync clear of counter and prescaler
//   load       in   1            sync load of load_val
//   load_val   in   4*NUM_DIGITS packed BCD preset
//   count      out  4*NUM_DIGITS packed BCD counter value
//   val        out  4            registered value of the currently scanned digit
//   digit_en   out  NUM_DIGITS   one-hot scan enable, lags val by exactly 1 clk
//   wrap       out  1            1-clk pulse on 9..9->0..0 (up) or 0..0->9..9 (down)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge)
//   - count=0, val=0, digit_en=0, wrap=0; prescaler=0, scan counter=0, scan index=0.
//   - Reset has effect mid-operation, on the next edge.
//   Priority
//   - rst_n > ena=0 (hold everything) > clear > load > tick.
//   Prescaler
//   - Counts 0..TICK_DIV-1 while ena=1 and run=1; holds while run=0.
//   - tick = prescaler==TICK_DIV-1 and run=1. The prescaler wraps to 0 on the same edge.
//   - clear or load forces the prescaler to 0.
//   Counter, on tick
//   - Up: digit0+1; a digit at 9 becomes 0 and carries into the next digit.
//   - Down: digit0-1; a digit at 0 becomes 9 and borrows from the next digit.
//   - All-9 up gives all-0; all-0 down gives all-9. wrap=1 for the cycle after that
//     edge, otherwise 0.
//   - up_dn is sampled on the tick edge only.
//   Load / clear
//   - load copies load_val into count. Any nibble >9 saturates to 9.
//   - clear sets count=0 and wins over a simultaneous load.
//   - Neither load nor clear asserts wrap. A tick in the same cycle is discarded.
//   Scan
//   - Runs independently of run, while ena=1.
//   - Scan counter counts 0..SCAN_DIV-1. At terminal count the index advances
//     0,1,..,NUM_DIGITS-1 and then back to 0.
//   - Every ena cycle: val <= count digit[index], using the pre-edge count.
//   - Every ena cycle: digit_en <= one-hot(index) delayed one stage, so digit_en
//     matches the downstream registered segments.
//   - After reset, the first nonzero digit_en is 4'b0001, two cycles after reset release.
//   Widths
//   - Prescaler width $clog2(TICK_DIV); scan counter width $clog2(SCAN_DIV).
//   - No arithmetic wider than 4 bits per decade.
// STRUCTURE
//   Shared package seg7_pkg holds:
//   - localparam BCD_MAX = 4'd9
//   - typedef bcd_t (logic [3:0])
//   - function bcd_sat(bcd_t) for load saturation
//   Sub-module bcd_digit: one decade cell with inputs (clk, rst_n, en, up_dn, cin,
//   clear, load, d) and outputs (q, cout). It is instantiated NUM_DIGITS times in a
//   carry/borrow chain. Prescaler, scanner and wrap detection live in the top level.
// TESTING
//   All tests use NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2.
//   1. Up count: load 16'h0099, run=1, up_dn=1; after 1 tick (4 clk) -> count=16'h0100, wrap=0.
//   2. Up wrap: load 16'h9999, up; after 1 tick -> count=16'h0000, wrap high exactly 1 clk.
//      Down wrap: from 16'h0000, down; after 1 tick -> count=16'h9999, wrap 1 clk.
//   3. Load rules: load_val=16'h1C3F -> count=16'h1939.
//      Assert clear and load together -> count=16'h0000, prescaler=0.
//   4. Scan: load 16'h1234, run=0.
//      - val steps 4,3,2,1,4 with 2 clk per digit.
//      - digit_en steps 0001,0010,0100,1000, each 1 clk after the matching val.
//   5. Freeze and reset: ena=0 for 10 clk mid-count -> count, val, digit_en and
//      prescaler unchanged.
//      Then rst_n=0 for 1 edge mid-count -> all outputs 0 on that edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the BCD counter and 7-segment display path.
// Holds the decade type, the decade maximum and the load saturation helper.
package seg7_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_sat(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with carry/borrow chaining.
// cin advances this digit; cout ripples the carry or borrow to the next decade.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       cin,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       cout
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (en) begin
      if (clear) begin
        q <= 4'd0;
      end else if (load) begin
        q <= bcd_sat(d);
      end else if (cin) begin
        if (up_dn) q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        else       q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
      end
    end
  end

  // Combinational so a full rollover ripples through every decade in one edge.
  assign cout = cin & (up_dn ? (q == BCD_MAX) : (q == 4'd0));

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with tick prescaler and digit scanner.
// digit_en trails val by one clock to line up with the registered segment decoder.
module bcd_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    run,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [3:0]              val,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    wrap
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0]  SC_TC    = SC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      presc;
  logic [SC_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [NUM_DIGITS-1:0] en_pipe;
  logic [NUM_DIGITS:0]   carry;
  logic [3:0]            digit_q [NUM_DIGITS];
  logic                  tick;

  assign tick     = run & (presc == PRE_TC);
  assign carry[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ena),
      .up_dn (up_dn),
      .cin   (carry[g]),
      .clear (clear),
      .load  (load),
      .d     (load_val[4*g +: 4]),
      .q     (digit_q[g]),
      .cout  (carry[g+1])
    );
    assign count[4*g +: 4] = digit_q[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      wrap  <= 1'b0;
    end else if (ena) begin
      // A carry out of the top decade only counts when the tick is not overridden.
      wrap <= carry[NUM_DIGITS] & ~clear & ~load;
      if (clear || load)  presc <= '0;
      else if (run)       presc <= (presc == PRE_TC) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      val      <= 4'd0;
      en_pipe  <= '0;
      digit_en <= '0;
    end else if (ena) begin
      val      <= digit_q[scan_idx];
      en_pipe  <= NUM_DIGITS'(1) << scan_idx;
      digit_en <= en_pipe;
      if (scan_cnt == SC_TC) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (4 digits, tick every 4 clk, scan every 2 clk).
// A decimal-valued reference model is checked every cycle alongside directed literal checks.
module tb_bcd_scan_counter;

  localparam int ND = 4;
  localparam int TD = 4;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          rst_n, ena, run, up_dn, clear, load;
  logic [15:0]   load_val;
  logic [15:0]   count;
  logic [3:0]    val;
  logic [ND-1:0] digit_en;
  logic          wrap;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // reference model state: counter held as a plain decimal number
  int m_cnt, m_pre, m_sc, m_idx, m_val, m_pipe, m_den;
  bit m_wrap;

  bcd_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .run      (run),
    .up_dn    (up_dn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .val      (val),
    .digit_en (digit_en),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic int digit_of(input int n, input int i);
    int v = n;
    for (int k = 0; k < i; k++) v = v / 10;
    return v % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r = '0;
    int v = n;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_sat(input logic [15:0] b);
    int r = 0;
    int w = 1;
    int nib;
    for (int k = 0; k < ND; k++) begin
      nib = int'(b[4*k +: 4]);
      if (nib > 9) nib = 9;
      r = r + nib * w;
      w = w * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  o_cnt, o_idx;
    bit  tk;
    if (!rst_n) begin
      m_cnt = 0; m_pre = 0; m_sc = 0; m_idx = 0;
      m_val = 0; m_pipe = 0; m_den = 0; m_wrap = 1'b0;
    end else if (ena) begin
      o_cnt  = m_cnt;
      o_idx  = m_idx;
      m_den  = m_pipe;
      m_pipe = 1 << o_idx;
      m_val  = digit_of(o_cnt, o_idx);
      tk     = run && (m_pre == TD - 1);
      m_wrap = 1'b0;
      if (clear) begin
        m_cnt = 0; m_pre = 0;
      end else if (load) begin
        m_cnt = from_bcd_sat(load_val); m_pre = 0;
      end else begin
        if (run) m_pre = (m_pre + 1) % TD;
        if (tk) begin
          if (up_dn) begin
            m_wrap = (m_cnt == 9999);
            m_cnt  = (m_cnt + 1) % 10000;
          end else begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + 9999) % 10000;
          end
        end
      end
      if (m_sc == SD - 1) begin
        m_sc  = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_sc = m_sc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", 32'(count), 32'(to_bcd(m_cnt)));
      check("model_val", 32'(val), 32'(m_val));
      check("model_digit_en", 32'(digit_en), 32'(m_den));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int exp_val [9] = '{4, 3, 3, 2, 2, 1, 1, 4, 4};
    int exp_en  [9] = '{1, 1, 2, 2, 4, 4, 8, 8, 1};

    rst_n = 1'b0; ena = 1'b1; run = 1'b0; up_dn = 1'b1;
    clear = 1'b0; load = 1'b0; load_val = '0;
    step(1);
    chk_en = 1'b1;
    check("reset_count", 32'(count), 32'h0);
    check("reset_val", 32'(val), 32'h0);
    check("reset_digit_en", 32'(digit_en), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;
    step(1);
    check("first_en_edge1", 32'(digit_en), 32'h0);
    step(1);
    check("first_en_edge2", 32'(digit_en), 32'h1);

    // up count with multi-decade carry
    load = 1'b1; load_val = 16'h0099; run = 1'b1; up_dn = 1'b1;
    step(1);
    load = 1'b0;
    step(4);
    check("up_carry_count", 32'(count), 32'h0100);
    check("up_carry_wrap", 32'(wrap), 32'h0);

    // up wrap then down wrap
    load = 1'b1; load_val = 16'h9999;
    step(1);
    load = 1'b0;
    step(3);
    check("up_wrap_pre", 32'(count), 32'h9999);
    step(1);
    check("up_wrap_count", 32'(count), 32'h0000);
    check("up_wrap_pulse", 32'(wrap), 32'h1);
    up_dn = 1'b0;
    step(1);
    check("up_wrap_end", 32'(wrap), 32'h0);
    step(3);
    check("dn_wrap_count", 32'(count), 32'h9999);
    check("dn_wrap_pulse", 32'(wrap), 32'h1);
    step(1);
    check("dn_wrap_end", 32'(wrap), 32'h0);

    // load saturation, clear priority, prescaler restart
    load = 1'b1; load_val = 16'h1C3F;
    step(1);
    load = 1'b0; run = 1'b0;
    check("load_sat", 32'(count), 32'h1939);
    clear = 1'b1; load = 1'b1; load_val = 16'h5555; run = 1'b1;
    step(1);
    clear = 1'b0; load = 1'b0; up_dn = 1'b1;
    check("clear_wins", 32'(count), 32'h0000);
    check("clear_no_wrap", 32'(wrap), 32'h0);
    step(3);
    check("presc_restart_pre", 32'(count), 32'h0000);
    step(1);
    check("presc_restart_tick", 32'(count), 32'h0001);

    // scan sequence from a known phase
    rst_n = 1'b0; run = 1'b0;
    step(1);
    rst_n = 1'b1; load = 1'b1; load_val = 16'h1234;
    step(1);
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      check($sformatf("scan_val_%0d", i), 32'(val), 32'(exp_val[i]));
      check($sformatf("scan_en_%0d", i), 32'(digit_en), 32'(exp_en[i]));
    end

    // freeze mid-count, then resume; prescaler must have held at 2
    run = 1'b1; up_dn = 1'b1;
    step(2);
    ena = 1'b0;
    step(10);
    check("freeze_count", 32'(count), 32'h1234);
    ena = 1'b1;
    step(1);
    check("resume_pre_tick", 32'(count), 32'h1234);
    step(1);
    check("resume_tick", 32'(count), 32'h1235);

    // reset mid-count
    step(1);
    rst_n = 1'b0;
    step(1);
    check("midreset_count", 32'(count), 32'h0);
    check("midreset_val", 32'(val), 32'h0);
    check("midreset_digit_en", 32'(digit_en), 32'h0);
    check("midreset_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;
    step(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
